// File: rtl/cv32e40p_instr_obi_responder.sv
// cv32e40p_instr_obi_responder: OBI instruction memory model with fixed latency, credit-limited grant and preload port.
module cv32e40p_instr_obi_responder #(
    parameter int          MEM_WORDS       = 1024,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int          LATENCY         = 1,
    parameter int          MAX_OUTSTANDING = 2,
    localparam int         AW              = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          instr_req_i,
    input  logic [31:0]   instr_addr_i,
    output logic          instr_gnt_o,
    output logic          instr_rvalid_o,
    output logic [31:0]   instr_rdata_o,
    output logic          instr_err_o,
    input  logic          gnt_stall_i,
    input  logic          load_we_i,
    input  logic [AW-1:0] load_addr_i,
    input  logic [31:0]   load_wdata_i,
    output logic [3:0]    outstanding_o
);
    logic [31:0]   mem [MEM_WORDS];
    logic [3:0]    cnt_q, cnt_d;
    logic [31:0]   off;
    logic          acc, in_oob, unused_lsb;
    logic [AW-1:0] in_idx;
    logic          hd_v, hd_oob;
    logic [AW-1:0] hd_idx;
    logic          rvalid_q, err_q;
    logic [31:0]   rdata_q;

    // Addresses below BASE_ADDR wrap to huge offsets and are flagged separately
    assign off        = instr_addr_i - BASE_ADDR;
    assign in_oob     = (instr_addr_i < BASE_ADDR) || ({2'b0, off[31:2]} >= 32'(MEM_WORDS));
    assign in_idx     = off[AW+1:2];
    assign unused_lsb = ^off[1:0];

    // Credit is judged on the registered count only, so a retiring response never frees a slot this cycle
    assign instr_gnt_o = rst_n & instr_req_i & ~gnt_stall_i & (cnt_q < 4'(MAX_OUTSTANDING));
    assign acc         = instr_req_i & instr_gnt_o;
    assign cnt_d       = cnt_q + {3'b0, acc} - {3'b0, rvalid_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    always_ff @(posedge clk) begin
        if (load_we_i) mem[load_addr_i] <= load_wdata_i;
    end

    // Stages ahead of the output register; LATENCY=1 feeds the output straight from acceptance
    generate
        if (LATENCY == 1) begin : g_direct
            assign hd_v   = acc;
            assign hd_idx = in_idx;
            assign hd_oob = in_oob;
        end else begin : g_pipe
            logic [LATENCY-2:0] v_q, o_q;
            logic [AW-1:0]      i_q [LATENCY-1];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_q <= '0;
                end else begin
                    v_q[0] <= acc;
                    for (int k = 1; k < LATENCY - 1; k++) v_q[k] <= v_q[k-1];
                end
            end
            always_ff @(posedge clk) begin
                i_q[0] <= in_idx;
                o_q[0] <= in_oob;
                for (int k = 1; k < LATENCY - 1; k++) begin
                    i_q[k] <= i_q[k-1];
                    o_q[k] <= o_q[k-1];
                end
            end
            assign hd_v   = v_q[LATENCY-2];
            assign hd_idx = i_q[LATENCY-2];
            assign hd_oob = o_q[LATENCY-2];
        end
    endgenerate

    // Final stage: memory is sampled at the same edge as a preload write, so old data is returned
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= hd_v;
            rdata_q  <= (hd_v && !hd_oob) ? mem[hd_idx] : '0;
            err_q    <= hd_v & hd_oob;
        end
    end

    assign instr_rvalid_o = rvalid_q;
    assign instr_rdata_o  = rdata_q;
    assign instr_err_o    = err_q;
    assign outstanding_o  = cnt_q;
endmodule

// File: tb/tb_cv32e40p_instr_obi_responder.sv
// tb_cv32e40p_instr_obi_responder: randomized OBI traffic checked against a queue-based response model.
module tb_cv32e40p_instr_obi_responder;
    localparam int          TMEM  = 64;
    localparam int          TAW   = $clog2(TMEM);
    localparam logic [31:0] TBASE = 32'h0000_0100;
    localparam int          TLAT  = 3;
    localparam int          TMAX  = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           instr_req_i = 1'b0;
    logic [31:0]    instr_addr_i = '0;
    logic           instr_gnt_o, instr_rvalid_o, instr_err_o;
    logic [31:0]    instr_rdata_o;
    logic           gnt_stall_i = 1'b0;
    logic           load_we_i = 1'b0;
    logic [TAW-1:0] load_addr_i = '0;
    logic [31:0]    load_wdata_i = '0;
    logic [3:0]     outstanding_o;

    cv32e40p_instr_obi_responder #(
        .MEM_WORDS(TMEM), .BASE_ADDR(TBASE), .LATENCY(TLAT), .MAX_OUTSTANDING(TMAX)
    ) dut (
        .clk(clk), .rst_n(rst_n), .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
        .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
        .instr_err_o(instr_err_o), .gnt_stall_i(gnt_stall_i), .load_we_i(load_we_i),
        .load_addr_i(load_addr_i), .load_wdata_i(load_wdata_i), .outstanding_o(outstanding_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        bit          oob;
        int          idx;
        logic [31:0] data;
    } rsp_t;

    rsp_t        q[$];
    logic [31:0] mem_m [TMEM];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, then at the falling edge compare against the model
    task automatic step(input logic r, input logic rq, input logic [31:0] ad, input logic st,
                        input logic we, input logic [TAW-1:0] la, input logic [31:0] wd);
        logic   eg;
        longint a, w;
        rsp_t   e;
        rst_n = r; instr_req_i = rq; instr_addr_i = ad; gnt_stall_i = st;
        load_we_i = we; load_addr_i = la; load_wdata_i = wd;
        @(negedge clk);
        if (!r) begin
            q.delete();
            chk("gnt_rst", 32'(instr_gnt_o), 32'(0));
            chk("rvalid_rst", 32'(instr_rvalid_o), 32'(0));
            chk("rdata_rst", instr_rdata_o, 32'(0));
            chk("err_rst", 32'(instr_err_o), 32'(0));
            chk("outst_rst", 32'(outstanding_o), 32'(0));
        end else begin
            eg = rq && !st && (q.size() < TMAX);
            chk("gnt", 32'(instr_gnt_o), 32'(eg));
            chk("outstanding", 32'(outstanding_o), 32'(q.size()));
            if (q.size() > 0 && q[0].due == cyc) begin
                chk("rvalid", 32'(instr_rvalid_o), 32'(1));
                chk("rdata", instr_rdata_o, q[0].data);
                chk("err", 32'(instr_err_o), 32'(q[0].oob));
                void'(q.pop_front());
            end else begin
                chk("rvalid_idle", 32'(instr_rvalid_o), 32'(0));
                chk("rdata_idle", instr_rdata_o, 32'(0));
                chk("err_idle", 32'(instr_err_o), 32'(0));
            end
            if (eg) begin
                a = longint'(ad);
                e.due = cyc + TLAT;
                e.data = '0;
                if (a < longint'(TBASE)) begin
                    e.oob = 1'b1; e.idx = 0;
                end else begin
                    w = (a - longint'(TBASE)) / 4;
                    e.oob = (w >= TMEM);
                    e.idx = e.oob ? 0 : int'(w);
                end
                q.push_back(e);
            end
            foreach (q[i]) if (q[i].due == cyc + 1) q[i].data = q[i].oob ? 32'h0 : mem_m[q[i].idx];
        end
        if (we) mem_m[la] = wd;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic fetch(input logic [31:0] ad);
        step(1'b1, 1'b1, ad, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        logic [31:0] ad;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, TBASE, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < TMEM; i++)
            step(1'b1, 1'b0, '0, 1'b0, 1'b1, TAW'(i), (i == 0) ? 32'h0000_0013 : $urandom);
        fetch(TBASE);
        idle(TLAT + 1);
        for (int i = 0; i < 4; i++) fetch(TBASE + 32'(4 * i));
        idle(TLAT + 2);
        fetch(TBASE + 32'(4 * TMEM));
        fetch(32'h0000_0000);
        idle(TLAT + 2);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, (i == 0) ? TBASE + 4 : TBASE + 32'hC, 1'b1, 1'b0, '0, '0);
        fetch(TBASE + 32'hC);
        idle(TLAT + 1);
        fetch(TBASE + 8);
        step(1'b1, 1'b1, TBASE + 12, 1'b0, 1'b1, TAW'(3), 32'hDEAD_BEEF);
        idle(TLAT + 2);
        fetch(TBASE);
        fetch(TBASE + 4);
        idle(1);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
        fetch(TBASE + 8);
        idle(TLAT + 2);
        for (int i = 0; i < 2000; i++) begin
            ad = ($urandom_range(0, 15) == 0) ? $urandom : TBASE - 16 + 32'($urandom_range(0, TMEM * 4 + 32));
            step($urandom_range(0, 199) != 0, $urandom_range(0, 3) != 0, ad, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0, TAW'($urandom_range(0, TMEM - 1)), $urandom);
        end
        idle(TLAT + 2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
